// File: rtl/receiver.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling, glitch rejection,
// framing-error detection and break handling.
`timescale 1ns/1ps
module receiver #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       done,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_C) begin
            cnt <= '0;
            // Start bit must still be low at its centre, otherwise it was a glitch.
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST_C) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST_C) begin
            cnt <= '0;
            if (rx_s) begin
              data  <= shreg;
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          // Line held low: wait for it to return high so a break yields one error only.
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: a slow instance (5208 clk/bit) and a fast one (16 clk/bit)
// driven with directed frames; a monitor per instance pops expected events on done/frame_err.
`timescale 1ns/1ps
module tb_receiver;

  localparam int CPB_F = 16;
  localparam int CPB_S = 5208;
  localparam int LAT_F = 2 + 1 + (CPB_F - 1) / 2 + 9 * CPB_F;
  localparam int LAT_S = 2 + 1 + (CPB_S - 1) / 2 + 9 * CPB_S;

  typedef struct {
    bit         ferr;
    logic [7:0] d;
    int         t;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_f, rx_f, rst_s, rx_sl;
  logic [7:0] data_f, data_s;
  logic       done_f, ferr_f, busy_f;
  logic       done_s, ferr_s, busy_s;

  int  cyc = 0;
  int  checks = 0;
  int  passed = 0;
  bit  busy_seen;
  ev_t q_f[$];
  ev_t q_s[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  receiver #(.CLKS_PER_BIT(CPB_F)) u_fast (
    .clk(clk), .rst(rst_f), .rx(rx_f),
    .data(data_f), .done(done_f), .frame_err(ferr_f), .busy(busy_f)
  );

  receiver #(.CLKS_PER_BIT(CPB_S)) u_slow (
    .clk(clk), .rst(rst_s), .rx(rx_sl),
    .data(data_s), .done(done_s), .frame_err(ferr_s), .busy(busy_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_lat(input string name, input int act, input int exp);
    checks++;
    if (act >= exp - 1 && act <= exp + 1) passed++;
    else $display("FAIL %s: got %0d clk, expected %0d +/-1 clk", name, act, exp);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst_f && (done_f || ferr_f)) begin
      chk("fast_done_and_ferr_together", {31'd0, done_f & ferr_f}, 32'd0);
      if (q_f.size() == 0) begin
        checks++;
        $display("FAIL fast_unexpected_event: done=%0b frame_err=%0b data=%02h, expected none",
                 done_f, ferr_f, data_f);
      end else begin
        e = q_f.pop_front();
        chk("fast_event_kind(frame_err)", {31'd0, ferr_f}, {31'd0, e.ferr});
        chk("fast_data", {24'd0, data_f}, {24'd0, e.d});
        chk_lat("fast_latency", cyc - e.t, LAT_F);
        if (done_f) chk("fast_busy_at_done", {31'd0, busy_f}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (!rst_s && (done_s || ferr_s)) begin
      chk("slow_done_and_ferr_together", {31'd0, done_s & ferr_s}, 32'd0);
      if (q_s.size() == 0) begin
        checks++;
        $display("FAIL slow_unexpected_event: done=%0b frame_err=%0b data=%02h, expected none",
                 done_s, ferr_s, data_s);
      end else begin
        e = q_s.pop_front();
        chk("slow_event_kind(frame_err)", {31'd0, ferr_s}, {31'd0, e.ferr});
        chk("slow_data", {24'd0, data_s}, {24'd0, e.d});
        chk_lat("slow_latency", cyc - e.t, LAT_S);
        if (done_s) chk("slow_busy_at_done", {31'd0, busy_s}, 32'd0);
      end
    end
  end

  task automatic bit_f(input logic v);
    rx_f = v;
    repeat (CPB_F) @(posedge clk);
    #1;
  endtask

  task automatic send_f(input logic [7:0] b, input logic stop);
    bit_f(1'b0);
    for (int i = 0; i < 8; i++) bit_f(b[i]);
    bit_f(stop);
  endtask

  task automatic bit_s(input logic v);
    rx_sl = v;
    repeat (CPB_S) @(posedge clk);
    #1;
  endtask

  task automatic send_s(input logic [7:0] b);
    bit_s(1'b0);
    for (int i = 0; i < 8; i++) bit_s(b[i]);
    bit_s(1'b1);
  endtask

  task automatic push_f(input bit ferr, input logic [7:0] d);
    ev_t e;
    e.ferr = ferr;
    e.d    = d;
    e.t    = cyc;
    q_f.push_back(e);
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] vec [4];
    logic [7:0] a5;
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h55; vec[3] = 8'h80;
    a5 = 8'hA5;

    rst_f = 1'b1; rst_s = 1'b1; rx_f = 1'b1; rx_sl = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", {24'd0, data_f}, 32'h00);
    chk("reset_done", {31'd0, done_f}, 32'd0);
    chk("reset_frame_err", {31'd0, ferr_f}, 32'd0);
    chk("reset_busy", {31'd0, busy_f}, 32'd0);
    rst_f = 1'b0; rst_s = 1'b0;

    // Idle line for 1000 clk: nothing must happen.
    busy_seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (busy_f || busy_s) busy_seen = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_busy_never", {31'd0, busy_seen}, 32'd0);
    chk("idle_data_fast", {24'd0, data_f}, 32'h00);
    chk("idle_data_slow", {24'd0, data_s}, 32'h00);

    fork
      begin
        ev_t e;
        e.ferr = 1'b0; e.d = 8'hAB; e.t = cyc;
        q_s.push_back(e);
        send_s(8'hAB);
        repeat (20) @(posedge clk);
        #1;
      end
      begin
        // Back-to-back frames with no idle gap.
        for (int i = 0; i < 4; i++) begin
          push_f(1'b0, vec[i]);
          send_f(vec[i], 1'b1);
        end
        repeat (5) @(posedge clk); #1;
        chk("b2b_final_data", {24'd0, data_f}, 32'h80);

        // Start-bit glitch.
        busy_seen = 1'b0;
        rx_f = 1'b0;
        repeat (3) @(posedge clk); #1;
        rx_f = 1'b1;
        repeat (30) begin
          @(negedge clk);
          if (busy_f) busy_seen = 1'b1;
        end
        @(posedge clk); #1;
        chk("glitch_busy_pulsed", {31'd0, busy_seen}, 32'd1);
        chk("glitch_back_idle", {31'd0, busy_f}, 32'd0);
        chk("glitch_data_kept", {24'd0, data_f}, 32'h80);

        // Framing error followed by a held-low break, then a good frame.
        push_f(1'b1, 8'h80);
        send_f(8'h3C, 1'b0);
        rx_f = 1'b0;
        repeat (40) @(posedge clk); #1;
        rx_f = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("break_released_idle", {31'd0, busy_f}, 32'd0);
        chk("ferr_data_kept", {24'd0, data_f}, 32'h80);
        push_f(1'b0, 8'hC3);
        send_f(8'hC3, 1'b1);
        repeat (5) @(posedge clk); #1;

        // Asynchronous reset in the middle of data bit 4 of 8'hA5.
        bit_f(1'b0);
        for (int i = 0; i < 4; i++) bit_f(a5[i]);
        rx_f = a5[4];
        repeat (8) @(posedge clk);
        #7 rst_f = 1'b1;
        #1;
        chk("midreset_data", {24'd0, data_f}, 32'h00);
        chk("midreset_busy", {31'd0, busy_f}, 32'd0);
        chk("midreset_done", {31'd0, done_f}, 32'd0);
        rx_f = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_f = 1'b0;
        repeat (20) @(posedge clk); #1;
        push_f(1'b0, 8'h5A);
        send_f(8'h5A, 1'b1);
        repeat (10) @(posedge clk); #1;
        chk("after_reset_data", {24'd0, data_f}, 32'h5A);
      end
    join

    repeat (5) @(posedge clk); #1;
    chk("fast_all_events_seen", q_f.size(), 32'd0);
    chk("slow_all_events_seen", q_s.size(), 32'd0);
    chk("slow_final_data", {24'd0, data_s}, 32'hAB);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- UART receiver (8N1): the receive-side counterpart of the team's `transmitter` block.
- Deserialises an asynchronous `rx` line into an 8-bit byte.
- Pulses `done` for one clock when a byte with a valid stop bit has been captured.
- Flags framing errors and rejects start-bit glitches.
- Sits between the board's serial input pin and the range-sensor command/data logic; runs on the same system clock as `transmitter`.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per UART bit. Must match `transmitter`. 5208 gives 9600 baud at 50 MHz. Legal range is 4 or more.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data  output  8  last correctly received byte, LSB first on the line.
- done  output  1  one-clock pulse; `data` is valid and updated in the same cycle.
- frame_err  output  1  one-clock pulse when the sampled stop bit is 0.
- busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset values (asynchronous, active-high):
  - data=8'h00, done=0, frame_err=0, busy=0.
  - State=IDLE, bit counter=0, clock counter=0.
  - Both synchroniser flops=1 (line idle).
- Input synchroniser: `rx` passes through a 2-flop synchroniser giving `rx_s`. All decisions use `rx_s`, which lags `rx` by 2 clk.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- Clock counter: width $clog2(CLKS_PER_BIT). Cleared on every state transition.
- IDLE:
  - busy=0.
  - If rx_s==0, go to START.
- START:
  - Count up to HALF.
  - At count==HALF: if rx_s==0, go to DATA with bit index 0. If rx_s==1, the start was a glitch: go to IDLE. No done, no frame_err.
- DATA:
  - Count up to CLKS_PER_BIT-1.
  - At that count, shift rx_s into shift register bit[index], LSB first.
  - After index 7, go to STOP; otherwise increment index.
- STOP:
  - Count up to CLKS_PER_BIT-1, then sample rx_s.
  - If rx_s==1: data<=shift register and done=1 for exactly one cycle. Go to IDLE.
  - If rx_s==0: frame_err=1 for one cycle; data is unchanged. Go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE.
  - A line held low (break) therefore produces exactly one frame_err and no spurious frames.
- Sampling point: every bit is sampled near its centre (HALF + k*CLKS_PER_BIT clocks after start-edge detection).
- Latency: done rises 2 + 1 + HALF + 9*CLKS_PER_BIT clk (±1) after the rx falling edge.
- `data` holds its value between frames. It is never altered by a bad or aborted frame.
- done and frame_err are never asserted in the same cycle.
- Back-to-back frames: a start bit directly after the stop bit is accepted, because IDLE is re-entered one cycle after the stop sample. This is compatible with `transmitter`'s stop-bit length.
- Reset mid-frame: returns to IDLE immediately with no done pulse. Any partial byte is discarded.
- No FIFO. A consumer that misses the done pulse loses nothing until the next byte overwrites `data`.

Test Plan:
1. Loopback at CLKS_PER_BIT=5208, 20 ns clock: `transmitter` tx drives rx, sending 8'hAB. Expect exactly one done pulse; data==8'hAB at the pulse; frame_err never 1; busy falls together with done.
2. CLKS_PER_BIT=16, bench drives frames 8'h00, 8'hFF, 8'h55, 8'h80 back-to-back with no idle gap. Expect 4 done pulses, data in order, each pulse 2+1+7+144 clk (±1) after its start edge.
3. CLKS_PER_BIT=16, rx driven low for 3 clk then high. Expect: busy pulses, then returns to IDLE; no done; no frame_err; data unchanged.
4. CLKS_PER_BIT=16, frame 8'h3C with stop bit 0, line held low for 40 clk, then high, then a valid 8'hC3 frame. Expect: one frame_err pulse; data stays at its previous value; then done with data==8'hC3.
5. CLKS_PER_BIT=16, rst asserted asynchronously (not clock-aligned) at data bit 4 of 8'hA5, then released and 8'h5A sent. Expect: outputs reset at once; no done for 8'hA5; done with data==8'h5A.
6. After reset with rx held high for 1000 clk: done, frame_err and busy all stay 0, and data==8'h00.
